// File: rtl/bin2onehot_seq.sv
// Sequential binary-to-one-hot decoder: accepts an index over valid/ready and
// holds the matching output bit for a programmable dwell, flagging bad indices.
module bin2onehot_seq #(
  parameter int unsigned N       = 64,
  parameter int unsigned DWELL_W = 8,
  localparam int unsigned K      = (N > 1) ? $clog2(N) : 1
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_i,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [K-1:0]       in_idx,
  input  logic [DWELL_W-1:0] in_dwell,
  output logic [N-1:0]       io_out,
  output logic               out_valid,
  output logic               busy,
  output logic               err
);

  typedef enum logic {IDLE, HOLD} state_t;

  // When N fills the index space every encodable index is legal.
  localparam bit FULL_RANGE = (64'(N) == (64'(1) << K));

  state_t             state;
  logic [DWELL_W-1:0] cnt;
  logic               accept;
  logic               idx_ok;
  logic [N-1:0]       onehot;
  logic [DWELL_W-1:0] dwell_eff;

  assign in_ready  = (state == IDLE) || (cnt == DWELL_W'(1));
  assign accept    = in_valid && in_ready;
  assign idx_ok    = FULL_RANGE ? 1'b1 : (in_idx < K'(N));
  assign onehot    = N'(1) << in_idx;
  assign dwell_eff = (in_dwell == '0) ? DWELL_W'(1) : in_dwell;

  // Accept in the last hold cycle reloads directly, so io_out has no zero gap.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state     <= IDLE;
      io_out    <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      err       <= 1'b0;
      cnt       <= '0;
    end else begin
      err <= 1'b0;
      if (accept) begin
        if (idx_ok) begin
          state     <= HOLD;
          io_out    <= onehot;
          out_valid <= 1'b1;
          busy      <= 1'b1;
          cnt       <= dwell_eff;
        end else begin
          state     <= IDLE;
          io_out    <= '0;
          out_valid <= 1'b0;
          busy      <= 1'b0;
          err       <= 1'b1;
          cnt       <= '0;
        end
      end else if (state == HOLD) begin
        if (cnt == DWELL_W'(1)) begin
          state     <= IDLE;
          io_out    <= '0;
          out_valid <= 1'b0;
          busy      <= 1'b0;
          cnt       <= '0;
        end else begin
          cnt <= cnt - DWELL_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_bin2onehot_seq.sv
// Directed and randomised checks of bin2onehot_seq in N=64 and N=48 builds.
module tb_bin2onehot_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  idx;
  logic [7:0]  dwell;
  logic        v64, v48;
  logic        r64, r48, ov64, ov48, b64, b48, e64, e48;
  logic [63:0] io64;
  logic [47:0] io48;

  bit          sel;
  logic [63:0] s_io;
  logic        s_ready, s_ov, s_busy, s_err;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  bin2onehot_seq #(.N(64), .DWELL_W(8)) dut64 (
    .wb_clk_i(clk), .wb_rst_i(rst), .in_valid(v64), .in_ready(r64),
    .in_idx(idx), .in_dwell(dwell), .io_out(io64), .out_valid(ov64),
    .busy(b64), .err(e64)
  );

  bin2onehot_seq #(.N(48), .DWELL_W(8)) dut48 (
    .wb_clk_i(clk), .wb_rst_i(rst), .in_valid(v48), .in_ready(r48),
    .in_idx(idx), .in_dwell(dwell), .io_out(io48), .out_valid(ov48),
    .busy(b48), .err(e48)
  );

  always_comb begin
    s_io    = sel ? {16'h0, io48} : io64;
    s_ready = sel ? r48  : r64;
    s_ov    = sel ? ov48 : ov64;
    s_busy  = sel ? b48  : b64;
    s_err   = sel ? e48  : e64;
  end

  typedef struct {
    bit          sel;
    logic [5:0]  idx;
    logic [7:0]  dwell;
    logic [63:0] exp_io;
    int          exp_d;
    bit          exp_err;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (dut N=%0d) at %0t: got %h, expected %h",
               name, sel ? 48 : 64, $time, act, exp);
    end
  endtask

  task automatic chk_state(input string name, input logic [63:0] exp_io,
                           input bit exp_ready, input bit exp_err);
    chk({name, ".io_out"},    s_io, exp_io);
    chk({name, ".out_valid"}, 64'(s_ov), 64'(exp_io != 0));
    chk({name, ".busy"},      64'(s_busy), 64'(exp_io != 0));
    chk({name, ".in_ready"},  64'(s_ready), 64'(exp_ready));
    chk({name, ".err"},       64'(s_err), 64'(exp_err));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one request from idle and follow it until the block is idle again.
  task automatic do_req(input bit s, input logic [5:0] i, input logic [7:0] d,
                        input logic [63:0] exp_io, input int exp_d, input bit exp_err);
    sel   = s;
    idx   = i;
    dwell = d;
    if (s) v48 = 1'b1; else v64 = 1'b1;
    tick();
    v48 = 1'b0;
    v64 = 1'b0;
    if (exp_err) begin
      chk_state("err_pulse", 64'h0, 1'b1, 1'b1);
      tick();
      chk_state("err_clear", 64'h0, 1'b1, 1'b0);
    end else begin
      for (int c = 1; c <= exp_d; c++) begin
        chk_state("hold", exp_io, c == exp_d, 1'b0);
        tick();
      end
      chk_state("release", 64'h0, 1'b1, 1'b0);
    end
  endtask

  vec_t vecs[8];

  initial begin
    vecs[0] = '{1'b0, 6'd5,  8'd3,   64'h0000_0000_0000_0020, 3, 1'b0};
    vecs[1] = '{1'b0, 6'd63, 8'd0,   64'h8000_0000_0000_0000, 1, 1'b0};
    vecs[2] = '{1'b0, 6'd0,  8'd1,   64'h0000_0000_0000_0001, 1, 1'b0};
    vecs[3] = '{1'b0, 6'd31, 8'd4,   64'h0000_0000_8000_0000, 4, 1'b0};
    vecs[4] = '{1'b1, 6'd50, 8'd5,   64'h0,                   0, 1'b1};
    vecs[5] = '{1'b1, 6'd47, 8'd2,   64'h0000_8000_0000_0000, 2, 1'b0};
    vecs[6] = '{1'b1, 6'd63, 8'd1,   64'h0,                   0, 1'b1};
    vecs[7] = '{1'b1, 6'd0,  8'd0,   64'h0000_0000_0000_0001, 1, 1'b0};

    rst = 1'b1; v64 = 1'b0; v48 = 1'b0; idx = '0; dwell = '0; sel = 1'b0;
    repeat (2) tick();
    sel = 1'b0; chk_state("reset64", 64'h0, 1'b1, 1'b0);
    sel = 1'b1; chk_state("reset48", 64'h0, 1'b1, 1'b0);
    rst = 1'b0;
    tick();
    sel = 1'b0; chk_state("post_reset64", 64'h0, 1'b1, 1'b0);

    foreach (vecs[k])
      do_req(vecs[k].sel, vecs[k].idx, vecs[k].dwell,
             vecs[k].exp_io, vecs[k].exp_d, vecs[k].exp_err);

    // Back-to-back with in_valid held: 1,1,2,2 then idle, no zero gap.
    sel = 1'b0; idx = 6'd0; dwell = 8'd2; v64 = 1'b1;
    tick();
    chk_state("b2b_c1", 64'h1, 1'b0, 1'b0);
    idx = 6'd1;
    tick();
    chk_state("b2b_c2", 64'h1, 1'b1, 1'b0);
    tick();
    v64 = 1'b0;
    chk_state("b2b_c3", 64'h2, 1'b0, 1'b0);
    tick();
    chk_state("b2b_c4", 64'h2, 1'b1, 1'b0);
    tick();
    chk_state("b2b_idle", 64'h0, 1'b1, 1'b0);

    // Out-of-range index accepted in the last hold cycle drops straight to idle.
    sel = 1'b1; idx = 6'd3; dwell = 8'd1; v48 = 1'b1;
    tick();
    chk_state("hold_then_bad", 64'h8, 1'b1, 1'b0);
    idx = 6'd60;
    tick();
    v48 = 1'b0;
    chk_state("bad_in_hold", 64'h0, 1'b1, 1'b1);
    tick();
    chk_state("bad_in_hold_clr", 64'h0, 1'b1, 1'b0);

    // Reset during the 2nd cycle of a long hold.
    sel = 1'b0; idx = 6'd7; dwell = 8'd10; v64 = 1'b1;
    tick();
    v64 = 1'b0;
    chk_state("long_c1", 64'h80, 1'b0, 1'b0);
    tick();
    chk_state("long_c2", 64'h80, 1'b0, 1'b0);
    rst = 1'b1;
    tick();
    chk_state("mid_reset", 64'h0, 1'b1, 1'b0);
    rst = 1'b0;
    tick();
    chk_state("after_reset", 64'h0, 1'b1, 1'b0);
    do_req(1'b0, 6'd9, 8'd2, 64'h200, 2, 1'b0);

    // Randomised requests on both builds against a simple reference.
    for (int r = 0; r < 300; r++) begin
      bit          s;
      logic [5:0]  ri;
      logic [7:0]  rd;
      bit          bad;
      s   = ($urandom_range(0, 1) == 1);
      ri  = 6'($urandom_range(0, 63));
      rd  = 8'($urandom_range(0, 4));
      bad = s && (ri >= 6'd48);
      do_req(s, ri, rd, 64'(1) << ri, (rd == 0) ? 1 : int'(rd), bad);
      if ($urandom_range(0, 3) == 0) tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  always @(negedge clk) begin
    assert ($onehot0(io64) && $onehot0(io48))
      else $error("one-hot violation io64=%h io48=%h", io64, io48);
  end

endmodule
